// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment scan driver.
//   HEX_GLYPH : 16-entry hex-to-segment table, active-high, bit order
//               {A,B,C,D,E,F,G,P} in bits 7..0, P always 0 in the table.
//   SEG_OFF   : catode value with every segment dark (active-low pins).
//   SEG_A..P  : bit positions of each segment inside a catode byte.
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_A = 7;
    localparam int SEG_B = 6;
    localparam int SEG_C = 5;
    localparam int SEG_D = 4;
    localparam int SEG_E = 3;
    localparam int SEG_F = 2;
    localparam int SEG_G = 1;
    localparam int SEG_P = 0;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry n is HEX_GLYPH[n]; listed from F down to 0 because the
    // concatenation fills the most significant element first.
    localparam logic [15:0][7:0] HEX_GLYPH = {
        8'h8E,  // F : A E F G
        8'h9E,  // E : A D E F G
        8'h7A,  // d : B C D E G
        8'h9C,  // C : A D E F
        8'h3E,  // b : C D E F G
        8'hEE,  // A : A B C E F G
        8'hF6,  // 9 : A B C D F G
        8'hFE,  // 8 : all
        8'hE0,  // 7 : A B C
        8'hBE,  // 6 : A C D E F G
        8'hB6,  // 5 : A C D F G
        8'h66,  // 4 : B C F G
        8'hF2,  // 3 : A B C D G
        8'hDA,  // 2 : A B D E G
        8'h60,  // 1 : B C
        8'hFC   // 0 : A B C D E F
    };

endpackage

// File: rtl/seg7_scan_driver_hex_decode.sv
// ----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational nibble + decimal point to active-low catode byte.
//   nibble : hex digit 0..F
//   dp     : 1 lights the decimal point
//   catode : {A,B,C,D,E,F,G,P}, 0 means segment lit
// ----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] catode
);

    logic [7:0] pattern;

    always_comb begin
        pattern        = HEX_GLYPH[nibble];
        pattern[SEG_P] = dp;
        catode         = ~pattern;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Each digit owns a slot of REFRESH_DIV cycles; the first GUARD_CYCLES of a
// slot keep every anode off so the previous digit's segments cannot ghost.
//
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   value       : 4*NUM_DIGITS hex nibbles, nibble i drives digit i (0 = right)
//   dp          : per-digit decimal point, 1 = lit
//   digit_en    : per-digit enable, 0 = blanked
//   load        : strobe capturing value/dp/digit_en
//   catode      : {A..G,P} active-low segments (registered)
//   anode       : one-hot digit select, polarity from ANODE_ACTIVE_LOW (registered)
//   frame_done  : one-cycle pulse in the cycle after each frame boundary
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 always stays visible); digit_en still applies on top.
//
// Handshake: load is a fire-and-forget strobe with no ready. Every cycle it
// is high captures the inputs into staging (last one wins); staging moves to
// the displayed shadow only at a frame boundary, so a frame is never torn.
// A load in the boundary cycle itself bypasses staging and is shown next.
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 100000,
    parameter int GUARD_CYCLES     = 4,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [7:0]              catode,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    // Inactive anode level for every bit.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] stage_value, shadow_value;
    logic [NUM_DIGITS-1:0]   stage_dp, shadow_dp;
    logic [NUM_DIGITS-1:0]   stage_en, shadow_en;
    logic                    pending;

    logic slot_end, boundary;
    assign slot_end = (cnt == CNT_LAST);
    assign boundary = slot_end && (idx == IDX_LAST);

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Staging, pending flag and display shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_value  <= '0;
            stage_dp     <= '0;
            stage_en     <= '0;
            pending      <= 1'b0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
        end else begin
            if (load) begin
                stage_value <= value;
                stage_dp    <= dp;
                stage_en    <= digit_en;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    shadow_value <= value;
                    shadow_dp    <= dp;
                    shadow_en    <= digit_en;
                end else if (pending) begin
                    shadow_value <= stage_value;
                    shadow_dp    <= stage_dp;
                    shadow_en    <= stage_en;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Current digit, taken from the shadow only.
    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic       cur_en;
    logic       visible;
    logic [7:0] dec_catode;

    assign cur_nibble = shadow_value[4*idx +: 4];
    assign cur_dp     = shadow_dp[idx];
    assign cur_en     = shadow_en[idx];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    // lz_blank[i] is set when nibble i and every nibble above it are zero.
    always_comb begin : lz_scan
        logic zeros_above;
        zeros_above = 1'b1;
        lz_blank    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zeros_above = zeros_above && (shadow_value[4*i +: 4] == 4'h0);
            lz_blank[i] = zeros_above;
        end
    end

    assign visible = cur_en && !lz_blank[idx];
`else
    assign visible = cur_en;
`endif

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .catode (dec_catode)
    );

    logic [NUM_DIGITS-1:0] anode_act;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [7:0]            catode_next;

    always_comb begin
        anode_act = '0;
        if (visible && (cnt >= CNT_GUARD)) begin
            anode_act = NUM_DIGITS'(1) << idx;
        end
        anode_next  = anode_act ^ ANODE_OFF;
        catode_next = visible ? dec_catode : SEG_OFF;
    end

    // Registered outputs: one cycle behind cnt/idx/shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            catode     <= SEG_OFF;
            anode      <= ANODE_OFF;
            frame_done <= 1'b0;
        end else begin
            catode     <= catode_next;
            anode      <= anode_next;
            frame_done <= boundary;
        end
    end

endmodule
